calc_controller: RTL and testbench
==================================

# calc_controller

Sequencing controller for the keypad calculator. It consumes debounced key codes from the keypad scanner and turns them into decimal operand entry, operator selection, arithmetic and error handling. It drives a signed result/entry value plus status flags toward the 7-segment and LED display logic. It sits between the keypad scanner and the display decoders at the calculator top level.

## Interface
- WIDTH, 16: signed operand/result width (two's complement)
- MAX_DIGITS, 4: maximum decimal digits per operand; 10^MAX_DIGITS−1 must fit in WIDTH−1 bits
- clock  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous, active-low reset
- keycode  in  4  key code from scanner, valid while keypressed=1
- keypressed  in  1  level, high while a key is held; synchronous to clock
- disp_value  out  WIDTH  signed value to display
- op_code  out  2  current operator: 0 add, 1 sub, 2 mul
- busy  out  1  high while computing
- error  out  1  overflow latched
- state_dbg  out  3  current FSM state encoding, for LEDs

## Operation
- Key event: keypressed=1 and key_prev=0; key_prev resets to 1, so a key held through reset release produces no event. keycode is sampled on the event cycle. One event per press, regardless of hold length.
- Key map:
  - 0x0–0x9: digit
  - 0xA: add
  - 0xB: sub
  - 0xC: mul
  - 0xD: clear all
  - 0xE: clear entry
  - 0xF: equals
- Digit append: X = X*10 + d, computed as (X<<3)+(X<<1)+d. Digits beyond MAX_DIGITS in one operand are ignored.
- States:
  - ENTER_A:
    - digit → append to A
    - operator → store op, go to OP_WAIT
    - 0xE → A=0
    - 0xF → ignored
  - OP_WAIT:
    - digit → B=d, go to ENTER_B
    - operator → replace op
    - 0xE, 0xF → ignored
  - ENTER_B:
    - digit → append to B
    - 0xE → B=0
    - 0xF → go to COMPUTE, with no chained op
    - operator → go to COMPUTE, latching the new op as pending
  - COMPUTE:
    - add/sub takes 1 cycle
    - mul runs WIDTH cycles of shift-add on magnitudes, then sign fix-up
    - all key events are dropped
    - on completion: if the result is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1], go to ERROR
    - else if an op is pending: A=R, op=pending, go to OP_WAIT
    - else go to RESULT
  - RESULT:
    - digit → A=d, go to ENTER_A
    - operator → A=R, store op, go to OP_WAIT
    - 0xE, 0xF → ignored
  - ERROR: only 0xD is accepted; all other keys are ignored.
  - 0xD in any state except COMPUTE: A=B=R=0, op=add, error=0, go to ENTER_A.
- disp_value per state:
  - ENTER_A, OP_WAIT: A
  - ENTER_B, COMPUTE: B
  - RESULT: R
  - ERROR: 0
- Overflow check for add/sub uses a WIDTH+1-bit sum. Mul uses a 2·WIDTH-bit product.

## Timing
- Reset values:
  - state = ENTER_A
  - A = B = R = 0
  - disp_value = 0
  - op_code = 0
  - busy = 0
  - error = 0
  - state_dbg = ENTER_A encoding
  - multiplier idle
- Event detected in cycle N → registers and outputs reflect it in cycle N+1.
- busy is high exactly during COMPUTE: 1 cycle for add/sub, WIDTH cycles for mul.
- The result or error is visible in the cycle after busy falls.
- error rises in the same cycle the state becomes ERROR, and stays high until 0xD.
- reset_n low at any time, including mid-multiply, forces all reset values immediately. The partial product is discarded.
- keypressed rising in the last COMPUTE cycle is dropped. key_prev still tracks it, so no event is generated later for that press.

## Structure
- calc_pkg holds:
  - state enum (ENTER_A, OP_WAIT, ENTER_B, COMPUTE, RESULT, ERROR)
  - key code constants (KEY_ADD, KEY_SUB, KEY_MUL, KEY_CLR, KEY_CE, KEY_EQ)
  - op encoding
- Sub-module calc_seq_mult:
  - start/done handshake
  - WIDTH-cycle signed shift-add multiplier
  - outputs the 2·WIDTH-bit product and an overflow flag
- Everything else lives in calc_controller.

## Test plan
- Keys 1,2,A,3,4,F → busy high 1 cycle, then disp_value=46, state RESULT, error=0.
- Keys 5,B,9,F → disp_value=−4 (0xFFFC).
- Keys 1,2,3,C,4,5,6,F → busy high exactly 16 cycles. 56088 overflows, so error=1 and disp_value=0. Then key D → error=0, disp_value=0, state ENTER_A.
- Chaining:
  - keys 2,A,3,A → disp_value=5, op add, state OP_WAIT
  - then 4,F → disp_value=9
- Entry limits and hold:
  - keys 1,2,3,4,5 → disp_value=1234
  - key 7 held 1000 cycles → exactly one append
  - key pressed during COMPUTE → ignored
- Reset mid-operation:
  - reset_n low during cycle 8 of a multiply → all outputs at reset values immediately
  - after release, keys 6,F → disp_value=6, state ENTER_A

Source files
------------

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the keypad calculator controller:
//   state_t   : controller FSM states (encoding is exported on state_dbg)
//   op_t      : operator encoding driven on op_code
//   KEY_*     : keypad codes for the non-digit keys
//   is_digit / is_op / key_to_op : key classification helpers
// ---------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_OP_WAIT = 3'd1,
        ST_ENTER_B = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_RESULT  = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_CLR = 4'hD;
    localparam logic [3:0] KEY_CE  = 4'hE;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'd9);
    endfunction

    function automatic logic is_op(input logic [3:0] key);
        return (key == KEY_ADD) || (key == KEY_SUB) || (key == KEY_MUL);
    endfunction

    function automatic op_t key_to_op(input logic [3:0] key);
        case (key)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_seq_mult.sv
// ---------------------------------------------------------------------------
// calc_seq_mult
// Sequential signed multiplier: shift-add on operand magnitudes, one partial
// product bit per cycle, sign applied to the final sum.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : one-cycle pulse; operands are captured on this edge
//   i_a, i_b       : signed operands
//   o_done         : high in the last of WIDTH cycles (counting the start
//                    cycle); o_product/o_overflow are valid in that cycle
//   o_product      : signed 2*WIDTH-bit product
//   o_overflow     : product does not fit in a signed WIDTH-bit value
// ---------------------------------------------------------------------------
module calc_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic signed [WIDTH-1:0]   i_a,
    input  logic signed [WIDTH-1:0]   i_b,
    output logic                      o_done,
    output logic signed [2*WIDTH-1:0] o_product,
    output logic                      o_overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_acc_next;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_neg;

    // Most-negative input maps to 2^(WIDTH-1), which is correct read unsigned.
    assign w_mag_a = i_a[WIDTH-1] ? $unsigned(-i_a) : $unsigned(i_a);
    assign w_mag_b = i_b[WIDTH-1] ? $unsigned(-i_b) : $unsigned(i_b);

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Bit 0 is consumed on the start edge, so the last bit is added
    // combinationally while r_cnt == WIDTH-1; the result is ready without
    // an extra cycle.
    assign o_done    = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign o_product = r_neg ? -$signed(w_acc_next) : $signed(w_acc_next);

    // Fits in WIDTH bits only if the top WIDTH+1 bits are all equal.
    assign o_overflow = ~((&o_product[2*WIDTH-1:WIDTH-1]) |
                          ~(|o_product[2*WIDTH-1:WIDTH-1]));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_neg    <= 1'b0;
        end else if (i_start) begin
            r_acc    <= w_mag_b[0] ? {{WIDTH{1'b0}}, w_mag_a} : '0;
            r_mcand  <= {{(WIDTH-1){1'b0}}, w_mag_a, 1'b0};
            r_mplier <= w_mag_b >> 1;
            r_cnt    <= CW'(1);
            r_busy   <= 1'b1;
            r_neg    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_controller.sv
// ---------------------------------------------------------------------------
// calc_controller
// Keypad calculator sequencer: key edge detection, decimal operand entry,
// operator selection, add/sub/mul evaluation, chaining and overflow error.
//   clock, reset_n : system clock, asynchronous active-low reset
//   keycode        : key code, meaningful while keypressed is high
//   keypressed     : level, high while a key is held (clock-synchronous)
//   disp_value     : signed value for the display (A, B, R or 0 by state)
//   op_code        : current operator (0 add, 1 sub, 2 mul)
//   busy           : high for every COMPUTE cycle
//   error          : overflow latched, cleared by the clear-all key
//   state_dbg      : FSM state encoding
// Key events are one-per-press: rising edge of keypressed. An event seen in
// cycle N is reflected on every register and output in cycle N+1.
// ---------------------------------------------------------------------------
module calc_controller
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [3:0]              keycode,
    input  logic                    keypressed,
    output logic signed [WIDTH-1:0] disp_value,
    output logic [1:0]              op_code,
    output logic                    busy,
    output logic                    error,
    output logic [2:0]              state_dbg
);

    localparam int DW = $clog2(MAX_DIGITS + 1);

    // Registered state
    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    op_t              r_op;
    logic             r_pend_valid;
    op_t              r_pend_op;
    logic [DW-1:0]    r_a_cnt;
    logic [DW-1:0]    r_b_cnt;
    logic             r_key_prev;
    logic             r_mul_start;
    logic [WIDTH-1:0] r_disp;
    logic             r_busy;
    logic             r_error;

    // Next-state values
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_r_nxt;
    op_t              w_op_nxt;
    logic             w_pend_valid_nxt;
    op_t              w_pend_op_nxt;
    logic [DW-1:0]    w_a_cnt_nxt;
    logic [DW-1:0]    w_b_cnt_nxt;
    logic             w_mul_start_nxt;
    logic [WIDTH-1:0] w_disp_nxt;

    // Datapath
    logic                      w_event;
    logic [WIDTH-1:0]          w_digit;
    logic [WIDTH:0]            w_sum;
    logic                      w_sum_ovf;
    logic                      w_mul_done;
    logic signed [2*WIDTH-1:0] w_mul_product;
    logic                      w_mul_ovf;
    logic                      w_mul_fits;
    logic                      w_calc_done;
    logic                      w_calc_ovf;
    logic [WIDTH-1:0]          w_calc_res;

    // X*10 + d without a multiplier.
    function automatic logic [WIDTH-1:0] append_digit(input logic [WIDTH-1:0] x,
                                                      input logic [WIDTH-1:0] d);
        return (x << 3) + (x << 1) + d;
    endfunction

    assign w_event = keypressed & ~r_key_prev;
    assign w_digit = {{(WIDTH-4){1'b0}}, keycode};

    // Add/sub in WIDTH+1 bits: overflow when the two top bits disagree.
    always_comb begin
        if (r_op == OP_SUB) begin
            w_sum = {r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b};
        end else begin
            w_sum = {r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b};
        end
    end
    assign w_sum_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

    calc_seq_mult #(
        .WIDTH(WIDTH)
    ) u_mult (
        .i_clk      (clock),
        .i_rst_n    (reset_n),
        .i_start    (r_mul_start),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_done     (w_mul_done),
        .o_product  (w_mul_product),
        .o_overflow (w_mul_ovf)
    );

    // The truncated product must sign-extend back to the full product.
    assign w_mul_fits = (w_mul_product ==
                         {{WIDTH{w_mul_product[WIDTH-1]}}, w_mul_product[WIDTH-1:0]});

    always_comb begin
        if (r_op == OP_MUL) begin
            w_calc_done = w_mul_done;
            w_calc_ovf  = w_mul_ovf | ~w_mul_fits;
            w_calc_res  = w_mul_product[WIDTH-1:0];
        end else begin
            w_calc_done = 1'b1;
            w_calc_ovf  = w_sum_ovf;
            w_calc_res  = w_sum[WIDTH-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt      = r_state;
        w_a_nxt          = r_a;
        w_b_nxt          = r_b;
        w_r_nxt          = r_r;
        w_op_nxt         = r_op;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_op_nxt    = r_pend_op;
        w_a_cnt_nxt      = r_a_cnt;
        w_b_cnt_nxt      = r_b_cnt;
        w_mul_start_nxt  = 1'b0;

        if (w_event && (r_state != ST_COMPUTE) && (keycode == KEY_CLR)) begin
            w_state_nxt      = ST_ENTER_A;
            w_a_nxt          = '0;
            w_b_nxt          = '0;
            w_r_nxt          = '0;
            w_op_nxt         = OP_ADD;
            w_pend_valid_nxt = 1'b0;
            w_a_cnt_nxt      = '0;
            w_b_cnt_nxt      = '0;
        end else begin
            case (r_state)
                ST_ENTER_A: begin
                    if (w_event) begin
                        if (is_digit(keycode)) begin
                            if (r_a_cnt < DW'(MAX_DIGITS)) begin
                                w_a_nxt     = append_digit(r_a, w_digit);
                                w_a_cnt_nxt = r_a_cnt + DW'(1);
                            end
                        end else if (is_op(keycode)) begin
                            w_op_nxt    = key_to_op(keycode);
                            w_state_nxt = ST_OP_WAIT;
                        end else if (keycode == KEY_CE) begin
                            w_a_nxt     = '0;
                            w_a_cnt_nxt = '0;
                        end
                    end
                end
                ST_OP_WAIT: begin
                    if (w_event) begin
                        if (is_digit(keycode)) begin
                            w_b_nxt     = w_digit;
                            w_b_cnt_nxt = DW'(1);
                            w_state_nxt = ST_ENTER_B;
                        end else if (is_op(keycode)) begin
                            w_op_nxt = key_to_op(keycode);
                        end
                    end
                end
                ST_ENTER_B: begin
                    if (w_event) begin
                        if (is_digit(keycode)) begin
                            if (r_b_cnt < DW'(MAX_DIGITS)) begin
                                w_b_nxt     = append_digit(r_b, w_digit);
                                w_b_cnt_nxt = r_b_cnt + DW'(1);
                            end
                        end else if (keycode == KEY_CE) begin
                            w_b_nxt     = '0;
                            w_b_cnt_nxt = '0;
                        end else if ((keycode == KEY_EQ) || is_op(keycode)) begin
                            // An operator key both evaluates and chains.
                            w_state_nxt      = ST_COMPUTE;
                            w_pend_valid_nxt = is_op(keycode);
                            w_pend_op_nxt    = key_to_op(keycode);
                            w_mul_start_nxt  = (r_op == OP_MUL);
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (w_calc_done) begin
                        if (w_calc_ovf) begin
                            w_state_nxt = ST_ERROR;
                        end else if (r_pend_valid) begin
                            w_r_nxt          = w_calc_res;
                            w_a_nxt          = w_calc_res;
                            w_op_nxt         = r_pend_op;
                            w_pend_valid_nxt = 1'b0;
                            w_state_nxt      = ST_OP_WAIT;
                        end else begin
                            w_r_nxt     = w_calc_res;
                            w_state_nxt = ST_RESULT;
                        end
                    end
                end
                ST_RESULT: begin
                    if (w_event) begin
                        if (is_digit(keycode)) begin
                            w_a_nxt     = w_digit;
                            w_a_cnt_nxt = DW'(1);
                            w_state_nxt = ST_ENTER_A;
                        end else if (is_op(keycode)) begin
                            w_a_nxt     = r_r;
                            w_op_nxt    = key_to_op(keycode);
                            w_state_nxt = ST_OP_WAIT;
                        end
                    end
                end
                default: begin
                    // ST_ERROR: only clear-all leaves, handled above.
                end
            endcase
        end

        case (w_state_nxt)
            ST_ENTER_A, ST_OP_WAIT: w_disp_nxt = w_a_nxt;
            ST_ENTER_B, ST_COMPUTE: w_disp_nxt = w_b_nxt;
            ST_RESULT:              w_disp_nxt = w_r_nxt;
            default:                w_disp_nxt = '0;
        endcase
    end

    // FSM, datapath and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_ENTER_A;
            r_a          <= '0;
            r_b          <= '0;
            r_r          <= '0;
            r_op         <= OP_ADD;
            r_pend_valid <= 1'b0;
            r_pend_op    <= OP_ADD;
            r_a_cnt      <= '0;
            r_b_cnt      <= '0;
            // A key already held when reset releases must not count.
            r_key_prev   <= 1'b1;
            r_mul_start  <= 1'b0;
            r_disp       <= '0;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_r          <= w_r_nxt;
            r_op         <= w_op_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_op    <= w_pend_op_nxt;
            r_a_cnt      <= w_a_cnt_nxt;
            r_b_cnt      <= w_b_cnt_nxt;
            r_key_prev   <= keypressed;
            r_mul_start  <= w_mul_start_nxt;
            r_disp       <= w_disp_nxt;
            r_busy       <= (w_state_nxt == ST_COMPUTE);
            r_error      <= (w_state_nxt == ST_ERROR);
        end
    end

    assign disp_value = r_disp;
    assign op_code    = r_op;
    assign busy       = r_busy;
    assign error      = r_error;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_calc_controller.sv
// Scoreboard bench for calc_controller.
// Result expectations (value, error, state, op, busy length) go into res_q and
// are popped by the monitor the cycle after busy falls. Snapshot expectations
// (value, error, state, op, busy) go into snap_q and are compared by the
// monitor at the next falling clock edge.
module tb_calc_controller;

  localparam logic [2:0] ST_EA = 3'd0;
  localparam logic [2:0] ST_OW = 3'd1;
  localparam logic [2:0] ST_EB = 3'd2;
  localparam logic [2:0] ST_RS = 3'd4;
  localparam logic [2:0] ST_ER = 3'd5;
  localparam logic [1:0] OPA = 2'd0;
  localparam logic [1:0] OPS = 2'd1;
  localparam logic [1:0] OPM = 2'd2;
  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_MUL = 4'hC;
  localparam logic [3:0] K_CLR = 4'hD;
  localparam logic [3:0] K_CE  = 4'hE;
  localparam logic [3:0] K_EQ  = 4'hF;

  typedef struct packed {
    logic [15:0] disp;
    logic        err;
    logic [2:0]  st;
    logic [1:0]  op;
    logic [7:0]  aux;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  keycode;
  logic        keypressed;
  logic signed [15:0] disp_value;
  logic [1:0]  op_code;
  logic        busy;
  logic        error;
  logic [2:0]  state_dbg;

  exp_t res_q[$];
  exp_t snap_q[$];
  int   total = 0;
  int   bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  calc_controller #(.WIDTH(16), .MAX_DIGITS(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .keycode    (keycode),
    .keypressed (keypressed),
    .disp_value (disp_value),
    .op_code    (op_code),
    .busy       (busy),
    .error      (error),
    .state_dbg  (state_dbg)
  );

  function automatic exp_t mk(input logic [15:0] d, input logic e, input logic [2:0] s,
                              input logic [1:0] o, input int aux);
    mk = {d, e, s, o, 8'(aux)};
  endfunction

  task automatic compare(input string name, input exp_t act, input exp_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got disp=%h err=%b st=%0d op=%0d aux=%0d, expected disp=%h err=%b st=%0d op=%0d aux=%0d",
               name, act.disp, act.err, act.st, act.op, act.aux,
               exp.disp, exp.err, exp.st, exp.op, exp.aux);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    int   blen;
    logic prev_busy;
    exp_t e;
    blen = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (snap_q.size() > 0) begin
        e = snap_q.pop_front();
        compare("snapshot", mk(disp_value, error, state_dbg, op_code, int'(busy)), e);
      end
      if (!reset_n) begin
        blen = 0;
        prev_busy = 1'b0;
      end else begin
        if (busy) begin
          blen++;
        end else if (prev_busy) begin
          if (res_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got disp=%h st=%0d, expected no result", disp_value, state_dbg);
          end else begin
            e = res_q.pop_front();
            compare("result", mk(disp_value, error, state_dbg, op_code, blen), e);
          end
          blen = 0;
        end
        prev_busy = busy;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press(input logic [3:0] k, input int hold = 2, input int idle = 2);
    @(negedge clock);
    keycode = k;
    keypressed = 1'b1;
    repeat (hold) @(negedge clock);
    keypressed = 1'b0;
    repeat (idle) @(negedge clock);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (res_q.size() == 0 && snap_q.size() == 0) break;
      @(negedge clock);
      #1;
    end
    if (res_q.size() != 0 || snap_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d results and %0d snapshots pending, expected 0",
               res_q.size(), snap_q.size());
      res_q.delete();
      snap_q.delete();
    end
  endtask

  task automatic snap(input exp_t e);
    @(negedge clock);
    #2;
    snap_q.push_back(e);
    drain();
  endtask

  task automatic expect_res(input exp_t e);
    res_q.push_back(e);
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    int n;
    // Key held through reset release must not produce an event.
    reset_n = 1'b0;
    keycode = 4'h5;
    keypressed = 1'b1;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (3) @(negedge clock);
    keypressed = 1'b0;
    snap(mk(16'd0, 0, ST_EA, OPA, 0));

    // 12 + 34
    press(4'h1); press(4'h2); press(K_ADD);
    snap(mk(16'd12, 0, ST_OW, OPA, 0));
    press(4'h3); press(4'h4);
    snap(mk(16'd34, 0, ST_EB, OPA, 0));
    expect_res(mk(16'd46, 0, ST_RS, OPA, 1));
    press(K_EQ); drain();

    // 5 - 9 = -4
    press(4'h5);
    snap(mk(16'd5, 0, ST_EA, OPA, 0));
    press(K_SUB); press(4'h9);
    expect_res(mk(16'hFFFC, 0, ST_RS, OPS, 1));
    press(K_EQ); drain();

    // 123 * 456 = 56088 overflows
    press(K_CLR);
    snap(mk(16'd0, 0, ST_EA, OPA, 0));
    press(4'h1); press(4'h2); press(4'h3); press(K_MUL);
    press(4'h4); press(4'h5); press(4'h6);
    expect_res(mk(16'd0, 1, ST_ER, OPM, 16));
    press(K_EQ); drain();
    press(4'h5);
    snap(mk(16'd0, 1, ST_ER, OPM, 0));
    press(K_CLR);
    snap(mk(16'd0, 0, ST_EA, OPA, 0));

    // Chaining: 2 + 3 + 4
    press(4'h2); press(K_ADD); press(4'h3);
    expect_res(mk(16'd5, 0, ST_OW, OPA, 1));
    press(K_ADD); drain();
    press(4'h4);
    expect_res(mk(16'd9, 0, ST_RS, OPA, 1));
    press(K_EQ); drain();

    // Chaining into mul: (7 - 2) * 4
    press(K_CLR);
    press(4'h7); press(K_SUB); press(4'h2);
    expect_res(mk(16'd5, 0, ST_OW, OPM, 1));
    press(K_MUL); drain();
    press(4'h4);
    expect_res(mk(16'd20, 0, ST_RS, OPM, 16));
    press(K_EQ); drain();

    // 9999 * 3 = 29997, then + 9999 overflows on add
    press(K_CLR);
    press(4'h9); press(4'h9); press(4'h9); press(4'h9); press(K_MUL); press(4'h3);
    expect_res(mk(16'd29997, 0, ST_OW, OPA, 16));
    press(K_ADD); drain();
    press(4'h9); press(4'h9); press(4'h9); press(4'h9);
    expect_res(mk(16'd0, 1, ST_ER, OPA, 1));
    press(K_EQ); drain();

    // Negative operand into mul: (5 - 9) * 3 = -12
    press(K_CLR);
    press(4'h5); press(K_SUB); press(4'h9);
    expect_res(mk(16'hFFFC, 0, ST_OW, OPM, 1));
    press(K_MUL); drain();
    press(4'h3);
    expect_res(mk(16'hFFF4, 0, ST_RS, OPM, 16));
    press(K_EQ); drain();

    // Entry limit, clear entry, long hold
    press(K_CLR);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    snap(mk(16'd1234, 0, ST_EA, OPA, 0));
    press(K_CE);
    snap(mk(16'd0, 0, ST_EA, OPA, 0));
    press(K_CLR);
    press(4'h7, 1000);
    snap(mk(16'd7, 0, ST_EA, OPA, 0));
    press(4'h8);
    snap(mk(16'd78, 0, ST_EA, OPA, 0));

    // Key during COMPUTE is dropped; operator from RESULT reuses R
    press(K_CLR);
    press(4'h3); press(K_MUL); press(4'h4);
    expect_res(mk(16'd12, 0, ST_RS, OPM, 16));
    press(K_EQ);
    press(4'h9);
    drain();
    press(K_ADD);
    snap(mk(16'd12, 0, ST_OW, OPA, 0));
    press(4'h3);
    snap(mk(16'd3, 0, ST_EB, OPA, 0));
    press(K_CE);
    snap(mk(16'd0, 0, ST_EB, OPA, 0));
    press(4'h5);
    expect_res(mk(16'd17, 0, ST_RS, OPA, 1));
    press(K_EQ); drain();

    // Reset in cycle 8 of a multiply
    press(K_CLR);
    press(4'h1); press(4'h2); press(K_MUL); press(4'h3);
    press(K_EQ, 1, 0);
    n = 0;
    while (!busy && n < 5) begin
      @(negedge clock);
      n++;
    end
    repeat (7) @(negedge clock);
    #2 reset_n = 1'b0;
    snap_q.push_back(mk(16'd0, 0, ST_EA, OPA, 0));
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    drain();
    press(4'h6); press(K_EQ);
    snap(mk(16'd6, 0, ST_EA, OPA, 0));

    repeat (20) @(negedge clock);
    total++;
    if (res_q.size() != 0 || snap_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d results and %0d snapshots pending, expected 0",
               res_q.size(), snap_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion by 500000ns, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
